// File: rtl/wb_pkg.sv
// Shared types for the vector writeback stage.
// Lane geometry, FSM state encoding and the packed lane vector.
package wb_pkg;

   localparam int N     = 16;
   localparam int LANES = 16;
   localparam int LW    = $clog2(LANES);

   typedef enum logic [1:0] {
      IDLE,
      GATHER,
      COMMIT
   } wb_state_t;

   typedef logic [LANES-1:0][N-1:0] lane_vec_t;

endpackage

// File: rtl/vec_writeback_if.sv
// Memory-stage -> writeback bundle: op handshake plus load lane return.
// master = memory stage (drives op and lanes), slave = writeback.
interface vec_writeback_if;
   import wb_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic            in_regwrite;
   logic            in_memtoreg;
   logic [3:0]      in_wa3;
   lane_vec_t       in_alu;
   logic            mem_lane_valid;
   logic [LW-1:0]   mem_lane_idx;
   logic [N-1:0]    mem_lane_data;

   modport master (
      output in_valid, in_regwrite, in_memtoreg, in_wa3, in_alu,
      output mem_lane_valid, mem_lane_idx, mem_lane_data,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_regwrite, in_memtoreg, in_wa3, in_alu,
      input  mem_lane_valid, mem_lane_idx, mem_lane_data,
      output in_ready
   );

endinterface

// File: rtl/lane_gather_buffer.sv
// Lane data registers + arrival mask for serially returned loads.
// clr/wr_* gather lanes, load_* takes a whole ALU vector, full_next flags completion.
module lane_gather_buffer
   import wb_pkg::*;
(
   input  logic          clk,
   input  logic          RST,
   input  logic          clr,
   input  logic          wr_en,
   input  logic [LW-1:0] wr_idx,
   input  logic [N-1:0]  wr_data,
   input  logic          load_en,
   input  lane_vec_t     load_vec,
   output logic          full_next,
   output lane_vec_t     vec_out
);

   logic [LANES-1:0] mask;
   logic [LANES-1:0] hit;
   lane_vec_t        data;

   assign hit = LANES'(1) << wr_idx;

   // The lane arriving this cycle counts toward completion.
   assign full_next = wr_en & (&(mask | hit));

   assign vec_out = data;

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         mask <= '0;
         data <= '0;
      end else begin
         if (clr)
            mask <= '0;
         else if (wr_en)
            mask <= mask | hit;
         if (load_en)
            data <= load_vec;
         else if (wr_en)
            data[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/vec_writeback.sv
// Vector writeback stage: ALU/load results -> one full-vector regfile write.
// Ports: clk, RST, bus (op + lanes), RegWriteW/wa3w/wd3, pend_valid/pend_wa3, lane_err.
module vec_writeback
   import wb_pkg::*;
(
   input  logic             clk,
   input  logic             RST,
   vec_writeback_if.slave   bus,
   output logic             RegWriteW,
   output logic [3:0]       wa3w,
   output lane_vec_t        wd3,
   output logic             pend_valid,
   output logic [3:0]       pend_wa3,
   output logic             lane_err
);

   wb_state_t state;
   logic      acc;
   logic      take_alu;
   logic      take_ld;
   logic      lane_wr;
   logic      stray;
   logic      full_next;
   lane_vec_t vec_out;
   lane_vec_t merged;

   assign bus.in_ready = (state != GATHER);
   assign acc      = bus.in_valid & bus.in_ready;
   assign take_alu = acc & bus.in_regwrite & ~bus.in_memtoreg;
   assign take_ld  = acc & bus.in_regwrite &  bus.in_memtoreg;
   assign lane_wr  = (state == GATHER) & bus.mem_lane_valid;
   assign stray    = (state != GATHER) & bus.mem_lane_valid;

   lane_gather_buffer u_buf (
      .clk       (clk),
      .RST       (RST),
      .clr       (take_ld),
      .wr_en     (lane_wr),
      .wr_idx    (bus.mem_lane_idx),
      .wr_data   (bus.mem_lane_data),
      .load_en   (take_alu),
      .load_vec  (bus.in_alu),
      .full_next (full_next),
      .vec_out   (vec_out)
   );

   // Final lane bypasses the buffer so the write lands the next cycle.
   always_comb begin
      merged = vec_out;
      merged[bus.mem_lane_idx] = bus.mem_lane_data;
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         RegWriteW  <= 1'b0;
         wa3w       <= '0;
         wd3        <= '0;
         pend_valid <= 1'b0;
         pend_wa3   <= '0;
         lane_err   <= 1'b0;
      end else begin
         RegWriteW <= 1'b0;
         lane_err  <= lane_err | stray;
         unique case (1'b1)
            (state == GATHER): begin
               pend_valid <= 1'b1;
               if (full_next) begin
                  state     <= COMMIT;
                  RegWriteW <= 1'b1;
                  wa3w      <= pend_wa3;
                  wd3       <= merged;
               end
            end
            default: begin
               if (bus.in_valid && bus.in_regwrite) begin
                  pend_wa3   <= bus.in_wa3;
                  pend_valid <= 1'b1;
                  if (bus.in_memtoreg) begin
                     state <= GATHER;
                  end else begin
                     state     <= COMMIT;
                     RegWriteW <= 1'b1;
                     wa3w      <= bus.in_wa3;
                     wd3       <= bus.in_alu;
                  end
               end else begin
                  state      <= IDLE;
                  pend_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vec_writeback.sv
// Self-checking bench for vec_writeback.
// Directed scenarios plus randomized ops against a transaction-level model.
module tb_vec_writeback;
   import wb_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       RegWriteW;
   logic [3:0] wa3w;
   lane_vec_t  wd3;
   logic       pend_valid;
   logic [3:0] pend_wa3;
   logic       lane_err;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] last_wa;
   lane_vec_t  last_wd;

   always #5 clk = ~clk;

   vec_writeback_if bus ();

   vec_writeback dut (
      .clk        (clk),
      .RST        (rst_n),
      .bus        (bus),
      .RegWriteW  (RegWriteW),
      .wa3w       (wa3w),
      .wd3        (wd3),
      .pend_valid (pend_valid),
      .pend_wa3   (pend_wa3),
      .lane_err   (lane_err)
   );

   task automatic idle_in();
      bus.in_valid       = 1'b0;
      bus.in_regwrite    = 1'b0;
      bus.in_memtoreg    = 1'b0;
      bus.in_wa3         = '0;
      bus.in_alu         = '0;
      bus.mem_lane_valid = 1'b0;
      bus.mem_lane_idx   = '0;
      bus.mem_lane_data  = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic lane_vec_t rand_vec();
      lane_vec_t v;
      for (int k = 0; k < LANES; k++) v[k] = 16'($urandom);
      return v;
   endfunction

   task automatic test_reset();
      idle_in();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (RegWriteW !== 1'b0 || wa3w !== 4'd0 || wd3 !== '0) begin
         errors++;
         $display("FAIL reset_write: we=%b wa=%0d wd=%h want 0", RegWriteW, wa3w, wd3);
      end
      checks++;
      if (pend_valid !== 1'b0 || pend_wa3 !== 4'd0 || lane_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_pend: pv=%b pwa=%0d err=%b want 0", pend_valid, pend_wa3, lane_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.in_ready !== 1'b1 || RegWriteW !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: rdy=%b we=%b want 1/0", bus.in_ready, RegWriteW);
      end
   endtask

   task automatic test_alu();
      lane_vec_t v;
      for (int k = 0; k < LANES; k++) v[k] = 16'(16'h1000 + k);
      bus.in_valid    = 1'b1;
      bus.in_regwrite = 1'b1;
      bus.in_memtoreg = 1'b0;
      bus.in_wa3      = 4'd5;
      bus.in_alu      = v;
      tick();
      idle_in();
      checks++;
      if (RegWriteW !== 1'b1 || wa3w !== 4'd5) begin
         errors++;
         $display("FAIL alu_write: we=%b wa=%0d want 1/5", RegWriteW, wa3w);
      end
      checks++;
      if (wd3[3] !== 16'h1003 || wd3 !== v) begin
         errors++;
         $display("FAIL alu_data: lane3=%h want 1003 wd=%h", wd3[3], wd3);
      end
      tick();
      checks++;
      if (RegWriteW !== 1'b0 || wa3w !== 4'd5 || wd3 !== v) begin
         errors++;
         $display("FAIL alu_hold: we=%b wa=%0d want 0/5", RegWriteW, wa3w);
      end
      last_wa = 4'd5;
      last_wd = v;
   endtask

   task automatic test_back_to_back();
      lane_vec_t v1, v2;
      v1 = rand_vec();
      v2 = rand_vec();
      bus.in_valid    = 1'b1;
      bus.in_regwrite = 1'b1;
      bus.in_memtoreg = 1'b0;
      bus.in_wa3      = 4'd1;
      bus.in_alu      = v1;
      tick();
      checks++;
      if (RegWriteW !== 1'b1 || wa3w !== 4'd1 || wd3 !== v1 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: we=%b wa=%0d rdy=%b want 1/1/1", RegWriteW, wa3w, bus.in_ready);
      end
      bus.in_wa3 = 4'd2;
      bus.in_alu = v2;
      tick();
      idle_in();
      checks++;
      if (RegWriteW !== 1'b1 || wa3w !== 4'd2 || wd3 !== v2 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second: we=%b wa=%0d rdy=%b want 1/2/1", RegWriteW, wa3w, bus.in_ready);
      end
      tick();
      checks++;
      if (RegWriteW !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: we=%b want 0", RegWriteW);
      end
      last_wa = 4'd2;
      last_wd = v2;
   endtask

   task automatic test_load();
      lane_vec_t exp;
      int        seq_idx[$];
      logic [15:0] seq_dat[$];
      for (int i = LANES - 1; i >= 0; i--) begin
         seq_idx.push_back(i);
         seq_dat.push_back(16'(16'hA0 + i));
         exp[i] = 16'(16'hA0 + i);
         if (i == 7) begin
            seq_idx.push_back(7);
            seq_dat.push_back(16'hFFFF);
            exp[7] = 16'hFFFF;
         end
      end
      bus.in_valid    = 1'b1;
      bus.in_regwrite = 1'b1;
      bus.in_memtoreg = 1'b1;
      bus.in_wa3      = 4'd9;
      tick();
      idle_in();
      checks++;
      if (RegWriteW !== 1'b0 || bus.in_ready !== 1'b0 || pend_valid !== 1'b1 || pend_wa3 !== 4'd9) begin
         errors++;
         $display("FAIL load_accept: we=%b rdy=%b pv=%b pwa=%0d want 0/0/1/9",
                  RegWriteW, bus.in_ready, pend_valid, pend_wa3);
      end
      for (int j = 0; j < seq_idx.size(); j++) begin
         bus.mem_lane_valid = 1'b1;
         bus.mem_lane_idx   = LW'(seq_idx[j]);
         bus.mem_lane_data  = seq_dat[j];
         tick();
         checks++;
         if (j < seq_idx.size() - 1) begin
            if (RegWriteW !== 1'b0 || bus.in_ready !== 1'b0 || pend_wa3 !== 4'd9) begin
               errors++;
               $display("FAIL load_gather[%0d]: we=%b rdy=%b pwa=%0d want 0/0/9",
                        j, RegWriteW, bus.in_ready, pend_wa3);
            end
         end else begin
            if (RegWriteW !== 1'b1 || wa3w !== 4'd9 || wd3 !== exp || wd3[7] !== 16'hFFFF) begin
               errors++;
               $display("FAIL load_commit: we=%b wa=%0d wd=%h want 1/9 %h", RegWriteW, wa3w, wd3, exp);
            end
         end
      end
      idle_in();
      tick();
      checks++;
      if (RegWriteW !== 1'b0 || bus.in_ready !== 1'b1 || pend_valid !== 1'b0 || lane_err !== 1'b0) begin
         errors++;
         $display("FAIL load_end: we=%b rdy=%b pv=%b err=%b want 0/1/0/0",
                  RegWriteW, bus.in_ready, pend_valid, lane_err);
      end
      last_wa = 4'd9;
      last_wd = exp;
   endtask

   task automatic test_random();
      for (int op = 0; op < 40; op++) begin
         int          kind;
         logic [3:0]  wa;
         lane_vec_t   v;
         logic [LANES-1:0] seen;
         int          cyc;
         kind = $urandom_range(0, 2);
         wa   = 4'($urandom);
         v    = rand_vec();
         idle_in();
         bus.in_valid    = 1'b1;
         bus.in_regwrite = (kind != 1);
         bus.in_memtoreg = (kind == 2);
         bus.in_wa3      = wa;
         bus.in_alu      = v;
         tick();
         idle_in();
         if (kind == 0) begin
            checks++;
            if (RegWriteW !== 1'b1 || wa3w !== wa || wd3 !== v || pend_valid !== 1'b1) begin
               errors++;
               $display("FAIL rnd_alu[%0d]: we=%b wa=%0d want 1/%0d", op, RegWriteW, wa3w, wa);
            end
            last_wa = wa;
            last_wd = v;
         end else if (kind == 1) begin
            checks++;
            if (RegWriteW !== 1'b0 || wa3w !== last_wa || wd3 !== last_wd || pend_valid !== 1'b0) begin
               errors++;
               $display("FAIL rnd_nowrite[%0d]: we=%b wa=%0d pv=%b want 0/%0d/0",
                        op, RegWriteW, wa3w, pend_valid, last_wa);
            end
         end else begin
            checks++;
            if (RegWriteW !== 1'b0 || bus.in_ready !== 1'b0 || pend_wa3 !== wa || pend_valid !== 1'b1) begin
               errors++;
               $display("FAIL rnd_ld_accept[%0d]: we=%b rdy=%b pwa=%0d want 0/0/%0d",
                        op, RegWriteW, bus.in_ready, pend_wa3, wa);
            end
            seen = '0;
            v    = last_wd;
            cyc  = 0;
            while (seen != '1 && cyc < 400) begin
               logic [LW-1:0] li;
               logic [N-1:0]  ld;
               logic          lv;
               lv = ($urandom_range(0, 3) != 0);
               li = LW'($urandom);
               ld = N'($urandom);
               bus.mem_lane_valid = lv;
               bus.mem_lane_idx   = li;
               bus.mem_lane_data  = ld;
               bus.in_valid       = 1'($urandom);
               bus.in_regwrite    = 1'b1;
               bus.in_memtoreg    = 1'($urandom);
               bus.in_wa3         = ~wa;
               bus.in_alu         = rand_vec();
               tick();
               cyc++;
               if (lv) begin
                  v[li]    = ld;
                  seen[li] = 1'b1;
               end
               checks++;
               if (seen == '1) begin
                  if (RegWriteW !== 1'b1 || wa3w !== wa || wd3 !== v) begin
                     errors++;
                     $display("FAIL rnd_ld_commit[%0d]: we=%b wa=%0d wd=%h want 1/%0d %h",
                              op, RegWriteW, wa3w, wd3, wa, v);
                  end
               end else if (RegWriteW !== 1'b0 || bus.in_ready !== 1'b0 || pend_wa3 !== wa) begin
                  errors++;
                  $display("FAIL rnd_ld_gather[%0d]: we=%b rdy=%b pwa=%0d want 0/0/%0d",
                           op, RegWriteW, bus.in_ready, pend_wa3, wa);
               end
            end
            if (seen != '1) begin
               errors++;
               $display("FAIL rnd_ld_budget[%0d]: lanes=%h want ffff", op, seen);
            end
            last_wa = wa;
            last_wd = v;
            idle_in();
         end
      end
      idle_in();
      tick();
      checks++;
      if (RegWriteW !== 1'b0 || lane_err !== 1'b0) begin
         errors++;
         $display("FAIL rnd_end: we=%b err=%b want 0/0", RegWriteW, lane_err);
      end
   endtask

   task automatic test_stray();
      idle_in();
      tick();
      checks++;
      if (lane_err !== 1'b0) begin
         errors++;
         $display("FAIL stray_pre: err=%b want 0", lane_err);
      end
      bus.mem_lane_valid = 1'b1;
      bus.mem_lane_idx   = 4'd3;
      bus.mem_lane_data  = 16'h5A5A;
      tick();
      idle_in();
      checks++;
      if (lane_err !== 1'b1 || RegWriteW !== 1'b0) begin
         errors++;
         $display("FAIL stray_set: err=%b we=%b want 1/0", lane_err, RegWriteW);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (lane_err !== 1'b1 || RegWriteW !== 1'b0 || wd3 !== last_wd) begin
            errors++;
            $display("FAIL stray_sticky[%0d]: err=%b we=%b want 1/0", c, lane_err, RegWriteW);
         end
      end
   endtask

   task automatic test_reset_mid_gather();
      lane_vec_t v;
      int        wr_seen;
      bus.in_valid    = 1'b1;
      bus.in_regwrite = 1'b1;
      bus.in_memtoreg = 1'b1;
      bus.in_wa3      = 4'd6;
      tick();
      idle_in();
      for (int i = 0; i < 8; i++) begin
         bus.mem_lane_valid = 1'b1;
         bus.mem_lane_idx   = LW'(i);
         bus.mem_lane_data  = 16'(16'hC0 + i);
         tick();
      end
      idle_in();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (RegWriteW !== 1'b0 || pend_valid !== 1'b0 || lane_err !== 1'b0 || wd3 !== '0) begin
         errors++;
         $display("FAIL midrst_async: we=%b pv=%b err=%b want 0/0/0", RegWriteW, pend_valid, lane_err);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wr_seen = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (RegWriteW !== 1'b0) wr_seen++;
      end
      checks++;
      if (wr_seen != 0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_nowrite: writes=%0d rdy=%b want 0/1", wr_seen, bus.in_ready);
      end
      v = rand_vec();
      bus.in_valid    = 1'b1;
      bus.in_regwrite = 1'b1;
      bus.in_memtoreg = 1'b0;
      bus.in_wa3      = 4'd3;
      bus.in_alu      = v;
      tick();
      idle_in();
      checks++;
      if (RegWriteW !== 1'b1 || wa3w !== 4'd3 || wd3 !== v) begin
         errors++;
         $display("FAIL midrst_alu: we=%b wa=%0d want 1/3", RegWriteW, wa3w);
      end
      tick();
      checks++;
      if (RegWriteW !== 1'b0) begin
         errors++;
         $display("FAIL midrst_end: we=%b want 0", RegWriteW);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      idle_in();
      test_reset();
      test_alu();
      test_back_to_back();
      test_load();
      test_random();
      test_stray();
      test_reset_mid_gather();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
